tea_decrypt_core: RTL and testbench
===================================

TEA_DECRYPT_CORE -- requirements
Module: tea_decrypt_core

Interface
REQ-001 Parameter ROUNDS, default 32, number of TEA decryption rounds per block (legal range 1..63).
REQ-002 Parameter DELTA, default 32'h9E3779B9, TEA key-schedule constant.
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  ciphertext block and key are valid.
REQ-007 in_ready  output  1  core can accept a block.
REQ-008 in_v0  input  32  ciphertext word 0.
REQ-009 in_v1  input  32  ciphertext word 1.
REQ-010 in_key  input  128  key: k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
REQ-011 out_valid  output  1  plaintext is valid.
REQ-012 out_ready  input  1  consumer accepts plaintext.
REQ-013 out_v0  output  32  plaintext word 0.
REQ-014 out_v1  output  32  plaintext word 1.
REQ-015 busy  output  1  high while rounds are in progress.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ROUND, DONE.
REQ-017 IDLE: in_ready=1; in_valid=1 captures in_v0, in_v1, in_key and a 6-bit round counter=0, sets sum=(DELTA*ROUNDS) mod 2^32 (0xC6EF3720 at defaults), and moves to ROUND.
REQ-018 ROUND: exactly one round per cycle, in this order with all arithmetic modulo 2^32 and logical shifts.
REQ-019 Round step 1: v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3).
REQ-020 Round step 2: v0 -= ((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1), where v1' is the step-1 result from the same cycle.
REQ-021 Round step 3: sum -= DELTA; counter += 1.
REQ-022 busy SHALL be 1 exactly in ROUND; in_ready=0 in ROUND and DONE.
REQ-023 After the round with counter==ROUNDS-1, the FSM SHALL move to DONE, with the final v0 and v1 on out_v0 and out_v1.
REQ-024 Latency: a handshake at edge T gives out_valid=1 after edge T+ROUNDS (T+32 at defaults).
REQ-025 DONE: out_valid=1; out_v0 and out_v1 are held stable until out_ready=1 is sampled.
REQ-026 An out_valid & out_ready edge SHALL return the FSM to IDLE; that cycle is a no-accept cycle.
REQ-027 out_valid SHALL NOT depend combinationally on out_ready.
REQ-028 in_valid, in_v0, in_v1 and in_key SHALL be ignored outside IDLE; no queueing.
REQ-029 Captured key words SHALL NOT change until the next IDLE accept, even if in_key toggles mid-block.
REQ-030 out_v0 and out_v1 SHALL be registers, updated only in ROUND; their values in IDLE and ROUND are don't-care for the consumer.
REQ-031 The sum register SHALL wrap modulo 2^32 with no saturation; the counter SHALL NOT wrap for legal ROUNDS.
REQ-032 Plaintext round trip: an encrypt of P with key K under the same DELTA and ROUNDS, then decrypt with this core, SHALL return P bit-exactly.

Reset
REQ-033 On reset=1, state SHALL be IDLE immediately, without waiting for a clock edge.
REQ-034 On reset=1, the outputs SHALL be in_ready=1, out_valid=0, busy=0, out_v0=0, out_v1=0.
REQ-035 On reset=1, sum, counter and the key registers SHALL be 0.
REQ-036 Reset asserted mid-ROUND or mid-DONE SHALL abort the block with no output; the first accept after deassertion starts cleanly.
REQ-037 in_valid sampled on the first edge after reset deassertion SHALL be accepted.

Verification
REQ-038 Known answer: key=0, in_v0=32'h41EA3A0A, in_v1=32'h94BAA940 -> out_v0=0, out_v1=0, out_valid exactly 32 cycles after the accept edge.
REQ-039 Round trip: random K and P, 1000 blocks, encrypted by the bench reference model -> decrypted output equals P; busy high for exactly 32 cycles per block.
REQ-040 Backpressure: out_ready=0 for 50 cycles in DONE, with in_valid and in_key toggling -> outputs stable, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle.
REQ-041 Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly ROUNDS+2 cycles apart, each result correct.
REQ-042 Reset at round 17 -> out_valid, busy and outputs go to 0 without a clock edge; the next block decrypts correctly.
REQ-043 ROUNDS=1 build: a single-round encrypt of v=(1,2) with key (1,2,3,4) -> decrypt returns (1,2) one cycle after the accept.

Source files
------------

// File: rtl/tea_decrypt_core_if.sv
// Handshake bundle for the TEA decryption core: ciphertext/key input
// channel and plaintext output channel, each with valid/ready.
interface tea_decrypt_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_v0;
    logic [31:0]  in_v1;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_v0;
    logic [31:0]  out_v1;

    // Producer/consumer side (drives ciphertext, accepts plaintext)
    modport master (
        output in_valid, in_v0, in_v1, in_key, out_ready,
        input  in_ready, out_valid, out_v0, out_v1
    );

    // Core side
    modport slave (
        input  in_valid, in_v0, in_v1, in_key, out_ready,
        output in_ready, out_valid, out_v0, out_v1
    );
endinterface

// File: rtl/tea_decrypt_core.sv
// Iterative TEA block decryptor: one decryption round per clock.
// A block is captured in IDLE, ROUNDS rounds run in ROUND, and the
// plaintext is held in DONE until the consumer takes it.
module tea_decrypt_core #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic              clk,
    input  logic              reset,
    tea_decrypt_core_if.slave bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Starting sum for decryption is the sum the encryptor ended with.
    localparam logic [63:0] SUM_FULL = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0] SUM_INIT = SUM_FULL[31:0];
    localparam logic [5:0]  LAST_CNT = 6'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [31:0] v0_q, v1_q, sum_q;
    logic [5:0]  cnt_q;
    logic [31:0] key_q  [4];
    logic [31:0] key_in [4];
    logic [31:0] out_v0_q, out_v1_q;

    logic [31:0] f1, v1_rnd, f2, v0_rnd;
    logic        accept;
    logic        last_round;

    // Split the 128-bit key into k0..k3 (k0 is the most significant word)
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            assign key_in[gi] = bus.in_key[127 - 32*gi -: 32];
        end
    endgenerate

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_round = (cnt_q == LAST_CNT);

    // State register; reset forces IDLE immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = ROUND;
            ROUND:   if (last_round)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One decryption round: v1 first, then v0 using the new v1
    always_comb begin
        f1     = ((v0_q << 4) + key_q[2]) ^ (v0_q + sum_q) ^ ((v0_q >> 5) + key_q[3]);
        v1_rnd = v1_q - f1;
        f2     = ((v1_rnd << 4) + key_q[0]) ^ (v1_rnd + sum_q) ^ ((v1_rnd >> 5) + key_q[1]);
        v0_rnd = v0_q - f2;
    end

    // Datapath: capture on accept, iterate in ROUND, publish on the last round
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0_q     <= '0;
            v1_q     <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            out_v0_q <= '0;
            out_v1_q <= '0;
            for (int i = 0; i < 4; i++) begin
                key_q[i] <= '0;
            end
        end else if (accept) begin
            v0_q  <= bus.in_v0;
            v1_q  <= bus.in_v1;
            sum_q <= SUM_INIT;
            cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                key_q[i] <= key_in[i];
            end
        end else if (state_q == ROUND) begin
            v0_q  <= v0_rnd;
            v1_q  <= v1_rnd;
            sum_q <= sum_q - DELTA;
            cnt_q <= cnt_q + 6'd1;
            if (last_round) begin
                out_v0_q <= v0_rnd;
                out_v1_q <= v1_rnd;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_v0    = out_v0_q;
    assign bus.out_v1    = out_v1_q;
    assign busy          = (state_q == ROUND);

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Self-checking bench for tea_decrypt_core: directed vectors, a TEA
// reference model, and a per-cycle monitor of the default-size core.
module tb_tea_decrypt_core;

    localparam int          R     = 32;
    localparam logic [31:0] DELTA = 32'h9E3779B9;
    localparam logic [127:0] KEY1234 = 128'h00000001_00000002_00000003_00000004;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic busy, busy1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    tea_decrypt_core_if bus ();
    tea_decrypt_core_if bus1 ();

    tea_decrypt_core #(.ROUNDS(R), .DELTA(DELTA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    tea_decrypt_core #(.ROUNDS(1), .DELTA(DELTA)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1),
        .busy  (busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        chk(name, {63'd0, act}, {63'd0, exp});
    endfunction

    // Reference TEA encryption (standard algorithm, n rounds)
    function automatic logic [63:0] tea_enc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [127:0] k, input int n);
        logic [31:0] y, z, s, k0, k1, k2, k3;
        y = a; z = b; s = '0;
        k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
        for (int r = 0; r < n; r++) begin
            s = s + DELTA;
            y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
        end
        return {y, z};
    endfunction

    // Reference TEA decryption (inverse of tea_enc)
    function automatic logic [63:0] tea_dec(input logic [31:0] a, input logic [31:0] b,
                                            input logic [127:0] k, input int n);
        logic [31:0] y, z, s, k0, k1, k2, k3;
        y = a; z = b; s = DELTA * 32'(n);
        k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
        for (int r = 0; r < n; r++) begin
            z = z - (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
            y = y - (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            s = s - DELTA;
        end
        return {y, z};
    endfunction

    // Per-cycle monitor: a block accepted at edge A keeps busy high for
    // R cycles, then shows the model plaintext until out_ready is seen.
    initial begin : monitor
        bit          pending;
        int          acc_at;
        int          el;
        logic [63:0] exp_pt;
        pending = 1'b0;
        acc_at  = 0;
        exp_pt  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk1("mon_rst_in_ready", bus.in_ready, 1'b1);
                chk1("mon_rst_out_valid", bus.out_valid, 1'b0);
                chk1("mon_rst_busy", busy, 1'b0);
                chk("mon_rst_out", {bus.out_v0, bus.out_v1}, 64'd0);
                pending = 1'b0;
            end else if (!pending) begin
                chk1("mon_idle_in_ready", bus.in_ready, 1'b1);
                chk1("mon_idle_busy", busy, 1'b0);
                chk1("mon_idle_out_valid", bus.out_valid, 1'b0);
                if (bus.in_valid === 1'b1) begin
                    pending = 1'b1;
                    acc_at  = cyc + 1;
                    exp_pt  = tea_dec(bus.in_v0, bus.in_v1, bus.in_key, R);
                end
            end else begin
                el = cyc - acc_at;
                chk1("mon_blk_in_ready", bus.in_ready, 1'b0);
                if (el < R) begin
                    chk1("mon_round_busy", busy, 1'b1);
                    chk1("mon_round_out_valid", bus.out_valid, 1'b0);
                end else begin
                    chk1("mon_done_busy", busy, 1'b0);
                    chk1("mon_done_out_valid", bus.out_valid, 1'b1);
                    chk("mon_done_data", {bus.out_v0, bus.out_v1}, exp_pt);
                    if (bus.out_ready === 1'b1) pending = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [127:0] k, output int acc);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_v0    = a;
        bus.in_v1    = b;
        bus.in_key   = k;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
        end
        chk1("send_handshake", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        acc = cyc;
        // Scramble inputs mid-block; the core must have captured them already
        bus.in_valid = 1'b0;
        bus.in_v0    = $urandom;
        bus.in_v1    = $urandom;
        bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(output int t);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) break;
        end
        chk1("wait_out_valid", bus.out_valid, 1'b1);
        t = cyc;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          acc, t, last, nacc, a;
        logic [63:0] p, c, hold;
        logic [127:0] k;

        bus.in_valid  = 1'b1;
        bus.in_v0     = 32'h41EA3A0A;
        bus.in_v1     = 32'h94BAA940;
        bus.in_key    = '0;
        bus.out_ready = 1'b1;
        bus1.in_valid = 1'b0;
        bus1.in_v0    = '0;
        bus1.in_v1    = '0;
        bus1.in_key   = '0;
        bus1.out_ready = 1'b1;

        // Reset state is visible before any clock edge
        #1 reset = 1'b1;
        #1;
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_out", {bus.out_v0, bus.out_v1}, 64'd0);

        // Model pins against hand-derived values
        chk("pin_kat_enc", tea_enc(32'd0, 32'd0, 128'd0, 32), 64'h41EA3A0A_94BAA940);
        chk("pin_kat_dec", tea_dec(32'h41EA3A0A, 32'h94BAA940, 128'd0, 32), 64'd0);
        chk("pin_r1_enc", tea_enc(32'd1, 32'd2, KEY1234, 1), 64'h9E377999_DBE8D113);

        // Known answer, with in_valid already high at reset release
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        acc = cyc + 1;
        @(posedge clk);
        #1;
        chk1("first_edge_accept", busy, 1'b1);
        bus.in_valid = 1'b0;
        wait_out(t);
        chk("kat_latency", 64'(t - acc), 64'(R));
        chk("kat_data", {bus.out_v0, bus.out_v1}, 64'd0);
        $display("kat: ct=41ea3a0a_94baa940 pt=%h latency=%0d", {bus.out_v0, bus.out_v1}, t - acc);

        // Round trip on random keys and plaintexts
        for (int i = 0; i < 1000; i++) begin
            p = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            c = tea_enc(p[63:32], p[31:0], k, R);
            send(c[63:32], c[31:0], k, acc);
            wait_out(t);
            chk("rt_latency", 64'(t - acc), 64'(R));
            chk("rt_plaintext", {bus.out_v0, bus.out_v1}, p);
            $display("rt %0d: key=%h ct=%h pt=%h", i, k, c, {bus.out_v0, bus.out_v1});
        end

        // Backpressure in DONE with inputs toggling
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(32'h41EA3A0A, 32'h94BAA940, 128'd0, acc);
        wait_out(t);
        hold = {bus.out_v0, bus.out_v1};
        chk("bp_data", hold, 64'd0);
        for (int j = 0; j < 50; j++) begin
            @(posedge clk);
            #1;
            bus.in_valid = j[0];
            bus.in_v0    = $urandom;
            bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_stable", {bus.out_v0, bus.out_v1}, hold);
            chk1("bp_in_ready", bus.in_ready, 1'b0);
            chk1("bp_out_valid", bus.out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("bp_release_idle", bus.in_ready, 1'b1);
        chk1("bp_release_out_valid", bus.out_valid, 1'b0);
        $display("backpressure: held pt=%h for 50 cycles", hold);

        // Back-to-back with in_valid held high
        @(posedge clk);
        #1;
        k = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key   = k;
        bus.in_v0    = $urandom;
        bus.in_v1    = $urandom;
        bus.in_valid = 1'b1;
        last = -1;
        nacc = 0;
        for (int n = 0; n < 6 * (R + 2) && nacc < 5; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) begin
                a = cyc + 1;
                if (last >= 0) chk("b2b_spacing", 64'(a - last), 64'(R + 2));
                $display("b2b accept %0d at cycle %0d", nacc, a);
                last = a;
                nacc++;
                @(posedge clk);
                #1;
                bus.in_v0 = $urandom;
                bus.in_v1 = $urandom;
            end
        end
        bus.in_valid = 1'b0;
        chk("b2b_count", 64'(nacc), 64'd5);
        wait_out(t);

        // Reset during round 17 aborts the block
        p = {$urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        c = tea_enc(p[63:32], p[31:0], k, R);
        send(c[63:32], c[31:0], k, acc);
        repeat (17) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk1("midrst_out_valid", bus.out_valid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_in_ready", bus.in_ready, 1'b1);
        chk("midrst_out", {bus.out_v0, bus.out_v1}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        send(32'h41EA3A0A, 32'h94BAA940, 128'd0, acc);
        wait_out(t);
        chk("postrst_latency", 64'(t - acc), 64'(R));
        chk("postrst_data", {bus.out_v0, bus.out_v1}, 64'd0);
        $display("reset at round 17 aborted; next block pt=%h", {bus.out_v0, bus.out_v1});

        // Single-round build
        @(posedge clk);
        #1;
        bus1.in_v0    = 32'h9E377999;
        bus1.in_v1    = 32'hDBE8D113;
        bus1.in_key   = KEY1234;
        bus1.in_valid = 1'b1;
        @(negedge clk);
        chk1("r1_in_ready", bus1.in_ready, 1'b1);
        @(posedge clk);
        #1 bus1.in_valid = 1'b0;
        @(negedge clk);
        chk1("r1_busy", busy1, 1'b1);
        chk1("r1_not_yet_valid", bus1.out_valid, 1'b0);
        @(negedge clk);
        chk1("r1_out_valid", bus1.out_valid, 1'b1);
        chk("r1_data", {bus1.out_v0, bus1.out_v1}, {32'd1, 32'd2});
        $display("rounds=1: ct=9e377999_dbe8d113 pt=%h", {bus1.out_v0, bus1.out_v1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
